// File: rtl/burrito.sv
// burrito: 32x32 register file feeding a combinational ALU with write-back.
// Ports: clk, rst_n, RegWrite, Addr_op1/op2/Destino, Operacion -> Dato1/2, Resultado, Zero.
module burrito #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] Addr_op1,
  input  logic [ADDR_W-1:0] Addr_op2,
  input  logic [ADDR_W-1:0] Addr_Destino,
  input  logic [2:0]        Operacion,
  output logic [DATA_W-1:0] Dato1,
  output logic [DATA_W-1:0] Dato2,
  output logic [DATA_W-1:0] Resultado,
  output logic              Zero
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_en;
  logic              slt;

  assign wr_en = RegWrite && (Addr_Destino != '0);

  // Reset preloads each register with its own index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= DATA_W'(i);
      end
    end else if (wr_en) begin
      regs[Addr_Destino] <= Resultado;
    end
  end

  // Register 0 is hard-wired to zero on the read side.
  assign Dato1 = (Addr_op1 == '0) ? '0 : regs[Addr_op1];
  assign Dato2 = (Addr_op2 == '0) ? '0 : regs[Addr_op2];

  assign slt = $signed(Dato1) < $signed(Dato2);

  always_comb begin
    Resultado = '0;
    case (Operacion)
      3'b000:  Resultado = Dato1 & Dato2;
      3'b001:  Resultado = Dato1 | Dato2;
      3'b010:  Resultado = Dato1 + Dato2;
      3'b110:  Resultado = Dato1 - Dato2;
      3'b111:  Resultado = {{(DATA_W-1){1'b0}}, slt};
      3'b100:  Resultado = ~(Dato1 | Dato2);
      default: Resultado = '0;
    endcase
  end

  assign Zero = (Resultado == '0);

endmodule

// File: tb/tb_burrito.sv
// tb_burrito: random + directed checks of burrito against a reference model.
// Model holds register contents as a plain array; ALU done with arithmetic.
module tb_burrito;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        RegWrite = 0;
  logic [4:0]  Addr_op1 = 0;
  logic [4:0]  Addr_op2 = 0;
  logic [4:0]  Addr_Destino = 0;
  logic [2:0]  Operacion = 0;
  logic [31:0] Dato1;
  logic [31:0] Dato2;
  logic [31:0] Resultado;
  logic        Zero;

  int total = 0;
  int bad = 0;

  bit [31:0] mdl [32];

  burrito dut (
    .clk(clk),
    .rst_n(rst_n),
    .RegWrite(RegWrite),
    .Addr_op1(Addr_op1),
    .Addr_op2(Addr_op2),
    .Addr_Destino(Addr_Destino),
    .Operacion(Operacion),
    .Dato1(Dato1),
    .Dato2(Dato2),
    .Resultado(Resultado),
    .Zero(Zero)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void mdl_reset();
    for (int i = 0; i < 32; i++) mdl[i] = i;
  endfunction

  function automatic bit [31:0] rd(int a);
    return (a == 0) ? 32'd0 : mdl[a];
  endfunction

  function automatic bit [31:0] alu(bit [31:0] a, bit [31:0] b, int op);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      0: return a & b;
      1: return a | b;
      2: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      6: return 32'((longint'(a) + 64'h1_0000_0000 - longint'(b)) % 64'h1_0000_0000);
      7: return (sa < sb) ? 32'd1 : 32'd0;
      4: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Apply one cycle: drive, check combinational outputs, clock, update model.
  task automatic cyc(bit we, int a1, int a2, int d, int op);
    bit [31:0] r;
    RegWrite = we;
    Addr_op1 = 5'(a1);
    Addr_op2 = 5'(a2);
    Addr_Destino = 5'(d);
    Operacion = 3'(op);
    #1;
    r = alu(rd(a1), rd(a2), op);
    check("dato1", Dato1, rd(a1));
    check("dato2", Dato2, rd(a2));
    check("resultado", Resultado, r);
    check("zero", {31'd0, Zero}, {31'd0, r == 0});
    @(posedge clk);
    if (rst_n && we && d != 0) mdl[d] = r;
    #1;
  endtask

  task automatic peek(int a, bit [31:0] exp, string tag);
    RegWrite = 0;
    Addr_op1 = 5'(a);
    #1;
    check(tag, Dato1, exp);
  endtask

  initial begin
    mdl_reset();
    #12;
    rst_n = 1;
    @(posedge clk);
    #1;
    // Reset-state read path
    RegWrite = 0; Addr_op1 = 1; Addr_op2 = 2; Operacion = 3'b010;
    #1;
    check("rst_res", Resultado, 32'd3);
    check("rst_zero", {31'd0, Zero}, 32'd0);
    cyc(0, 1, 2, 5, 2);
    cyc(0, 1, 2, 5, 2);
    peek(5, 32'd5, "reg5_nowr");
    // Write-back sequence
    cyc(1, 1, 2, 5, 0);
    peek(5, 32'd0, "reg5_and");
    cyc(1, 3, 1, 6, 1);
    peek(6, 32'd3, "reg6_or");
    cyc(1, 5, 6, 7, 2);
    peek(7, 32'd3, "reg7_add");
    // SUB / SLT / Zero
    cyc(0, 3, 3, 0, 6);
    check("sub_zero", {31'd0, Zero}, 32'd1);
    cyc(0, 2, 3, 0, 7);
    cyc(1, 0, 1, 4, 6);
    peek(4, 32'hFFFF_FFFF, "reg4_neg1");
    Addr_op2 = 1; Operacion = 3'b111;
    #1;
    check("slt_signed", Resultado, 32'd1);
    cyc(0, 4, 1, 0, 7);
    // Reg0 write ignored, self-overwrite
    cyc(1, 3, 3, 0, 2);
    peek(0, 32'd0, "reg0");
    cyc(1, 3, 3, 3, 2);
    peek(3, 32'd6, "reg3_self");
    // Wraparound and unused op
    cyc(1, 0, 1, 8, 6);
    cyc(0, 8, 1, 0, 2);
    Addr_op1 = 8; Addr_op2 = 1; Operacion = 3'b010;
    #1;
    check("wrap_zero", {31'd0, Zero}, 32'd1);
    cyc(0, 7, 6, 0, 3);
    cyc(0, 7, 6, 0, 5);
    // Random traffic
    for (int n = 0; n < 300; n++) begin
      int ops[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
      cyc(1'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), ops[$urandom_range(0, 7)]);
    end
    // Async reset mid-cycle
    cyc(1, 1, 1, 5, 2);
    cyc(1, 2, 2, 6, 2);
    #2;
    rst_n = 0;
    mdl_reset();
    #1;
    peek(5, 32'd5, "arst5");
    peek(6, 32'd6, "arst6");
    peek(7, 32'd7, "arst7");
    cyc(1, 5, 6, 7, 2);
    peek(7, 32'd7, "arst_nowr");
    rst_n = 1;
    cyc(1, 5, 6, 7, 2);
    peek(7, 32'd11, "post_rst_wr");
    for (int n = 0; n < 100; n++) begin
      cyc(1'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 32; i++) peek(i, rd(i), "final_regs");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
